// File: rtl/des_round_engine.sv
// rtl/des_round_engine.sv - Iterative DES Feistel core, one round per clock, on-the-fly key schedule
// des_f_function is the combinational Feistel f (E, key mix, S1-S8, P) used by the round engine.

module des_f_function (
    input  logic [31:0] r_i,
    input  logic [47:0] k_i,
    output logic [31:0] f_o
);
    localparam int unsigned E_T [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,  8,  9, 10, 11,
        12, 13, 12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21,
        22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};
    localparam int unsigned P_T [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};
    // Each S-box is 64 nibbles, row-major, entry 0 in the top nibble.
    localparam logic [255:0] SBOX_T [8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

    logic [47:0] ex;
    logic [47:0] x;
    logic [5:0]  six;
    logic [5:0]  idx;
    logic [7:0]  sh;
    logic [31:0] s_out;

    always_comb begin
        ex    = '0;
        x     = '0;
        six   = '0;
        idx   = '0;
        sh    = '0;
        s_out = '0;
        f_o   = '0;
        for (int i = 0; i < 48; i++) begin
            ex[47 - i] = r_i[5'(32 - E_T[i])];
        end
        x = ex ^ k_i;
        for (int s = 0; s < 8; s++) begin
            six = x[47 - 6*s -: 6];
            idx = {six[5], six[0], six[4:1]};
            sh  = 8'd252 - {idx, 2'b00};
            s_out[31 - 4*s -: 4] = 4'(SBOX_T[s] >> sh);
        end
        for (int i = 0; i < 32; i++) begin
            f_o[31 - i] = s_out[5'(32 - P_T[i])];
        end
    end
endmodule

module des_round_engine (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] data_in,
    input  logic [63:0] key,
    input  logic        decrypt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] data_out
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int unsigned PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
    localparam int unsigned PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    state_t      state_q, state_d;
    logic [31:0] l_q, l_d, r_q, r_d;
    logic [27:0] c_q, c_d, d_q, d_d;
    logic [3:0]  round_q, round_d;
    logic        mode_q, mode_d;
    logic        out_valid_q, out_valid_d;
    logic [63:0] data_out_q, data_out_d;

    logic [55:0] pc1_key;
    logic [1:0]  shift;
    logic [27:0] c_rot, d_rot;
    logic [55:0] cd_rot;
    logic [47:0] subkey;
    logic [31:0] f_val;
    logic        parity_unused;

    assign parity_unused = ^{key[56], key[48], key[40], key[32], key[24], key[16], key[8], key[0]};

    function automatic logic [27:0] rot28(input logic [27:0] v, input logic [1:0] n, input logic right);
        logic [27:0] res;
        case ({right, n})
            3'b001:  res = {v[26:0], v[27]};
            3'b010:  res = {v[25:0], v[27:26]};
            3'b101:  res = {v[0], v[27:1]};
            3'b110:  res = {v[1:0], v[27:2]};
            default: res = v;
        endcase
        return res;
    endfunction

    always_comb begin
        pc1_key = '0;
        for (int i = 0; i < 56; i++) begin
            pc1_key[55 - i] = key[6'(64 - PC1_T[i])];
        end
    end

    // Decrypt walks the schedule backwards: no rotation for K16, then right shifts.
    always_comb begin
        case (round_q)
            4'd0:              shift = mode_q ? 2'd0 : 2'd1;
            4'd1, 4'd8, 4'd15: shift = 2'd1;
            default:           shift = 2'd2;
        endcase
    end

    assign c_rot  = rot28(c_q, shift, mode_q);
    assign d_rot  = rot28(d_q, shift, mode_q);
    assign cd_rot = {c_rot, d_rot};

    always_comb begin
        subkey = '0;
        for (int i = 0; i < 48; i++) begin
            subkey[47 - i] = cd_rot[6'(56 - PC2_T[i])];
        end
    end

    des_f_function u_f (
        .r_i (r_q),
        .k_i (subkey),
        .f_o (f_val)
    );

    always_comb begin
        state_d     = state_q;
        l_d         = l_q;
        r_d         = r_q;
        c_d         = c_q;
        d_d         = d_q;
        round_d     = round_q;
        mode_d      = mode_q;
        out_valid_d = out_valid_q;
        data_out_d  = data_out_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    l_d        = data_in[63:32];
                    r_d        = data_in[31:0];
                    {c_d, d_d} = pc1_key;
                    mode_d     = decrypt;
                    round_d    = 4'd0;
                    state_d    = RUN;
                end
            end
            RUN: begin
                c_d     = c_rot;
                d_d     = d_rot;
                l_d     = r_q;
                r_d     = l_q ^ f_val;
                round_d = round_q + 4'd1;
                if (round_q == 4'd15) begin
                    data_out_d  = {l_q ^ f_val, r_q};
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            l_q         <= '0;
            r_q         <= '0;
            c_q         <= '0;
            d_q         <= '0;
            round_q     <= '0;
            mode_q      <= 1'b0;
            out_valid_q <= 1'b0;
            data_out_q  <= '0;
        end else begin
            state_q     <= state_d;
            l_q         <= l_d;
            r_q         <= r_d;
            c_q         <= c_d;
            d_q         <= d_d;
            round_q     <= round_d;
            mode_q      <= mode_d;
            out_valid_q <= out_valid_d;
            data_out_q  <= data_out_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign data_out  = data_out_q;
endmodule

// File: tb/tb_des_round_engine.sv
// tb/tb_des_round_engine.sv - Scoreboard bench for des_round_engine against a software DES model
module tb_des_round_engine;
    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] data_in;
    logic [63:0] key;
    logic        decrypt;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] data_out;

    des_round_engine dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .key       (key),
        .decrypt   (decrypt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    logic [63:0] exp_q[$];
    int          acc_q[$];
    logic        prev_ov = 1'b0;
    int          acc_front;

    localparam logic [63:0] KEY_V = 64'h133457799BBCDFF1;
    localparam logic [63:0] PT_V  = 64'hCC00CCFFF0AAF0AA;
    localparam logic [63:0] CT_V  = 64'h0A4CD99543423234;

    int M_PC1 [56] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,19,11,3,60,52,44,36,
                       63,55,47,39,31,23,15,7,62,54,46,38,30,22,14,6,61,53,45,37,29,21,13,5,28,20,12,4};
    int M_PC2 [48] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                       41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
    int M_E [48]   = '{32,1,2,3,4,5,4,5,6,7,8,9,8,9,10,11,12,13,12,13,14,15,16,17,
                       16,17,18,19,20,21,20,21,22,23,24,25,24,25,26,27,28,29,28,29,30,31,32,1};
    int M_P [32]   = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};
    int M_SH [16]  = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
    int M_S [8][64] = '{
        '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
          4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
        '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
          0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
        '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
          13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
        '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
          10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
        '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
          4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
        '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
          9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
        '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
          1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
        '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
          7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

    // Subkey n is PC-2 of PC-1(key) halves rotated left by the cumulative shift count.
    function automatic logic [47:0] model_subkey(input logic [63:0] k, input int n);
        logic [55:0] cd;
        logic [27:0] c, d;
        logic [47:0] sk;
        int total;
        for (int i = 0; i < 56; i++) cd[55 - i] = k[64 - M_PC1[i]];
        total = 0;
        for (int r = 0; r < n; r++) total += M_SH[r];
        c = cd[55:28];
        d = cd[27:0];
        c = (c << total) | (c >> (28 - total));
        d = (d << total) | (d >> (28 - total));
        cd = {c, d};
        for (int i = 0; i < 48; i++) sk[47 - i] = cd[56 - M_PC2[i]];
        return sk;
    endfunction

    function automatic logic [31:0] model_f(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] e;
        logic [31:0] s, p;
        int six, row, col;
        for (int i = 0; i < 48; i++) e[47 - i] = r[32 - M_E[i]];
        e = e ^ k;
        s = '0;
        for (int b = 0; b < 8; b++) begin
            six = int'((e >> (42 - 6*b)) & 48'h3F);
            row = ((six >> 4) & 2) | (six & 1);
            col = (six >> 1) & 15;
            s = (s << 4) | 32'(M_S[b][row*16 + col]);
        end
        for (int i = 0; i < 32; i++) p[31 - i] = s[32 - M_P[i]];
        return p;
    endfunction

    function automatic logic [63:0] model_des(input logic [63:0] d, input logic [63:0] k, input logic dec);
        logic [31:0] l, r, t;
        l = d[63:32];
        r = d[31:0];
        for (int n = 1; n <= 16; n++) begin
            t = r;
            r = l ^ model_f(r, model_subkey(k, dec ? 17 - n : n));
            l = t;
        end
        return {r, l};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && !prev_ov) begin
                if (acc_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_valid: got out_valid=1 expected no pending block");
                end else begin
                    acc_front = acc_q.pop_front();
                    check("latency", 64'(cyc - acc_front), 64'd16);
                end
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_output: got %h expected nothing", data_out);
                end else begin
                    check("data_out", data_out, exp_q.pop_front());
                end
            end
        end
        prev_ov = out_valid;
    end

    // mode: 0 plain, 1 scramble inputs during the block, 2 keep in_valid high with junk inputs
    task automatic issue(input logic [63:0] d, input logic [63:0] k, input logic dec, input int mode, output int acc);
        int n;
        n = 0;
        acc = -1;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_wait", 64'(in_ready), 64'd1);
        if (!in_ready) return;
        data_in  = d;
        key      = k;
        decrypt  = dec;
        in_valid = 1'b1;
        exp_q.push_back(model_des(d, k, dec));
        acc = cyc + 1;
        acc_q.push_back(acc);
        @(posedge clk);
        #1;
        if (mode == 0) in_valid = 1'b0;
        if (mode == 1) begin
            for (int i = 0; i < 16; i++) begin
                data_in  = {$urandom, $urandom};
                key      = {$urandom, $urandom};
                decrypt  = 1'($urandom);
                in_valid = 1'($urandom);
                @(posedge clk);
                #1;
            end
            in_valid = 1'b0;
        end
        if (mode == 2) begin
            data_in = {$urandom, $urandom};
            key     = {$urandom, $urandom};
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("drain", 64'(exp_q.size()), 64'd0);
    endtask

    int acc, prev_acc;
    logic [63:0] bp_exp;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; data_in = '0; key = '0; decrypt = 1'b0; out_ready = 1'b1;
        #12;
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_data_out", data_out, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        check("model_k1", 48'(model_subkey(KEY_V, 1)), 64'h1B02EFFC7072);
        check("model_enc", model_des(PT_V, KEY_V, 1'b0), CT_V);
        check("model_dec", model_des(CT_V, KEY_V, 1'b1), PT_V);

        // Known-answer encrypt with round-1 internal state
        issue(PT_V, KEY_V, 1'b0, 0, acc);
        @(negedge clk);
        check("enc_k1", 64'(dut.subkey), 64'h1B02EFFC7072);
        @(posedge clk);
        @(negedge clk);
        check("round1_l", 64'(dut.l_q), 64'hF0AAF0AA);
        check("round1_r", 64'(dut.r_q), 64'hEF4A6544);
        drain();

        // Known-answer decrypt: first subkey must be K16
        issue(CT_V, KEY_V, 1'b1, 0, acc);
        @(negedge clk);
        check("dec_first_key", 64'(dut.subkey), 64'(model_subkey(KEY_V, 16)));
        drain();

        // Parity bits flipped, inputs scrambled after accept
        issue(PT_V, KEY_V ^ 64'h0101010101010101, 1'b0, 1, acc);
        check("model_parity", model_des(PT_V, KEY_V ^ 64'h0101010101010101, 1'b0), CT_V);
        drain();

        // Backpressure
        @(posedge clk);
        #1 out_ready = 1'b0;
        issue(PT_V, KEY_V, 1'b0, 0, acc);
        bp_exp = model_des(PT_V, KEY_V, 1'b0);
        for (int i = 0; i < 40 && !out_valid; i++) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_valid", 64'(out_valid), 64'd1);
            check("bp_data", data_out, bp_exp);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            in_valid = 1'($urandom);
            data_in  = {$urandom, $urandom};
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_ready", 64'(in_ready), 64'd1);
        check("bp_release_valid", 64'(out_valid), 64'd0);
        check("bp_single", 64'(exp_q.size()), 64'd0);
        repeat (20) @(posedge clk);
        #1;
        check("bp_no_queue", 64'(out_valid), 64'd0);

        // Reset in the middle of round 7
        issue(PT_V, KEY_V, 1'b0, 0, acc);
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_data_out", data_out, 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        exp_q.delete();
        acc_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        issue(PT_V, KEY_V, 1'b0, 0, acc);
        drain();

        // Back-to-back random blocks
        prev_acc = -1;
        for (int b = 0; b < 4; b++) begin
            issue({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 2, acc);
            if (b > 0) check("spacing", 64'(acc - prev_acc), 64'd18);
            prev_acc = acc;
        end
        in_valid = 1'b0;
        drain();

        // Random blocks with idle gaps
        for (int b = 0; b < 6; b++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            issue({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 0, acc);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
